// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins and the etcher core: raw pins in,
// conditioned level/press/release/step pulses out. Bit order {RIGHT, LEFT, DOWN, UP}.
interface btn_conditioner_if #(
    parameter int N = 4
);
    logic [N-1:0] BTN_RAW;
    logic [N-1:0] BTN_LEVEL;
    logic [N-1:0] BTN_PRESS;
    logic [N-1:0] BTN_RELEASE;
    logic [N-1:0] BTN_STEP;

    // Pin/stimulus side: drives the raw buttons, observes the conditioned outputs.
    modport master (
        output BTN_RAW,
        input  BTN_LEVEL,
        input  BTN_PRESS,
        input  BTN_RELEASE,
        input  BTN_STEP
    );

    // Conditioner side.
    modport slave (
        input  BTN_RAW,
        output BTN_LEVEL,
        output BTN_PRESS,
        output BTN_RELEASE,
        output BTN_STEP
    );
endinterface

// File: rtl/btn_conditioner.sv
// Per-channel synchroniser, debouncer and typematic step generator for the
// direction buttons. All outputs come straight from flops.
module btn_conditioner #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int REPEAT_DELAY    = 12_500_000,
    parameter int REPEAT_PERIOD   = 2_500_000
) (
    input  logic              CLK_25MHZ,
    input  logic              RESET,
    btn_conditioner_if.slave  btn
);
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W    = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    typedef logic [DB_W-1:0]  db_cnt_t;
    typedef logic [RPT_W-1:0] rpt_cnt_t;

    localparam db_cnt_t  DB_LAST    = db_cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam rpt_cnt_t DELAY_LAST = rpt_cnt_t'(REPEAT_DELAY - 1);
    localparam rpt_cnt_t PERIOD_LAST = rpt_cnt_t'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            logic       sync1_q, sync2_q;
            logic       stable_q, stable_d;
            db_cnt_t    db_cnt_q, db_cnt_d;
            logic       rise, fall;
            rpt_state_t state_q, state_d;
            rpt_cnt_t   rpt_cnt_q, rpt_cnt_d;
            logic       press_q, release_q;
            logic       step_q, step_d;

            // Debounce: count consecutive samples that disagree with the accepted level.
            always_comb begin
                stable_d = stable_q;
                db_cnt_d = '0;
                rise     = 1'b0;
                fall     = 1'b0;
                if (sync2_q != stable_q) begin
                    if (db_cnt_q == DB_LAST) begin
                        stable_d = sync2_q;
                        rise     = sync2_q;
                        fall     = ~sync2_q;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
            end

            // Repeat FSM; a debounced fall overrides any step that is due in that cycle.
            always_comb begin
                state_d   = state_q;
                rpt_cnt_d = rpt_cnt_q;
                step_d    = 1'b0;
                if (fall) begin
                    state_d   = ST_IDLE;
                    rpt_cnt_d = '0;
                end else begin
                    unique case (state_q)
                        ST_IDLE: begin
                            if (rise) begin
                                step_d    = 1'b1;
                                rpt_cnt_d = '0;
                                state_d   = ST_DELAY;
                            end
                        end
                        ST_DELAY: begin
                            if (rpt_cnt_q == DELAY_LAST) begin
                                step_d    = 1'b1;
                                rpt_cnt_d = '0;
                                state_d   = ST_REPEAT;
                            end else begin
                                rpt_cnt_d = rpt_cnt_q + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (rpt_cnt_q == PERIOD_LAST) begin
                                step_d    = 1'b1;
                                rpt_cnt_d = '0;
                            end else begin
                                rpt_cnt_d = rpt_cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            state_d   = ST_IDLE;
                            rpt_cnt_d = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge CLK_25MHZ or posedge RESET) begin
                if (RESET) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    stable_q  <= 1'b0;
                    db_cnt_q  <= '0;
                    state_q   <= ST_IDLE;
                    rpt_cnt_q <= '0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    step_q    <= 1'b0;
                end else begin
                    sync1_q   <= btn.BTN_RAW[gi];
                    sync2_q   <= sync1_q;
                    stable_q  <= stable_d;
                    db_cnt_q  <= db_cnt_d;
                    state_q   <= state_d;
                    rpt_cnt_q <= rpt_cnt_d;
                    press_q   <= rise;
                    release_q <= fall;
                    step_q    <= step_d;
                end
            end

            assign btn.BTN_LEVEL[gi]   = stable_q;
            assign btn.BTN_PRESS[gi]   = press_q;
            assign btn.BTN_RELEASE[gi] = release_q;
            assign btn.BTN_STEP[gi]    = step_q;
        end
    endgenerate
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timings; outputs
// are logged per cycle and checked against hand-computed cycle positions.
module tb_btn_conditioner;
    localparam int N    = 4;
    localparam int HIST = 4096;

    logic clk = 1'b0;
    logic rst;

    btn_conditioner_if #(.N(N)) bus ();

    btn_conditioner #(
        .N(N),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .CLK_25MHZ(clk),
        .RESET(rst),
        .btn(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [N-1:0] level_hist [0:HIST-1];
    logic [N-1:0] press_hist [0:HIST-1];
    logic [N-1:0] rel_hist   [0:HIST-1];
    logic [N-1:0] step_hist  [0:HIST-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: sample outputs 1 ns after the edge and log them under the new cycle index.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < HIST) begin
            level_hist[cyc] = bus.BTN_LEVEL;
            press_hist[cyc] = bus.BTN_PRESS;
            rel_hist[cyc]   = bus.BTN_RELEASE;
            step_hist[cyc]  = bus.BTN_STEP;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    function automatic logic [31:0] step_train(input int ch, input int start, input int len);
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < len; r++) v[r] = step_hist[start + r][ch];
        return v;
    endfunction

    // OR of a logged output over [from, to]; sel 0=level 1=press 2=release 3=step.
    function automatic logic [N-1:0] any_out(input int sel, input int from, input int to);
        logic [N-1:0] v;
        v = '0;
        for (int c = from; c <= to; c++) begin
            case (sel)
                0:       v |= level_hist[c];
                1:       v |= press_hist[c];
                2:       v |= rel_hist[c];
                default: v |= step_hist[c];
            endcase
        end
        return v;
    endfunction

    function automatic logic [31:0] all_outs();
        return {16'h0, bus.BTN_LEVEL, bus.BTN_PRESS, bus.BTN_RELEASE, bus.BTN_STEP};
    endfunction

    int p, p2, pu, pd, pr, c0, cr;

    initial begin
        rst = 1'b1;
        bus.BTN_RAW = '0;
        run(3);
        chk("reset_outputs", all_outs(), 32'h0);
        rst = 1'b0;
        run(3);

        // Clean press on UP
        bus.BTN_RAW = 4'b0001;
        p = cyc + 6;
        run(8);
        chk("clean_pre_level", {28'h0, level_hist[p-1]}, 32'h0);
        chk("clean_level",     {28'h0, level_hist[p]},   32'h1);
        chk("clean_press",     {28'h0, press_hist[p]},   32'h1);
        chk("clean_step",      {28'h0, step_hist[p]},    32'h1);
        chk("clean_press_w1",  {28'h0, press_hist[p+1]}, 32'h0);
        chk("clean_step_w1",   {28'h0, step_hist[p+1]},  32'h0);

        // Release UP
        bus.BTN_RAW = 4'b0000;
        c0 = cyc + 6;
        run(18);
        chk("up_release",      {28'h0, rel_hist[c0]},   32'h1);
        chk("up_release_lvl",  {28'h0, level_hist[c0]}, 32'h0);
        chk("up_no_step_after", {28'h0, any_out(3, c0, c0 + 12)}, 32'h0);

        // Bounce: runs of three 1s separated by single 0s, then steady 1
        c0 = cyc + 1;
        for (int i = 0; i < 40; i++) begin
            bus.BTN_RAW[0] = (i % 4 != 3);
            tick();
        end
        bus.BTN_RAW[0] = 1'b1;
        p = cyc + 6;
        run(10);
        chk("bounce_quiet", {16'h0, any_out(0, c0, p-1), any_out(1, c0, p-1), any_out(2, c0, p-1), any_out(3, c0, p-1)}, 32'h0);
        chk("bounce_press", {28'h0, press_hist[p]}, 32'h1);
        chk("bounce_press_once", {28'h0, any_out(1, p+1, p+9)}, 32'h0);
        bus.BTN_RAW[0] = 1'b0;
        run(10);

        // Auto-repeat on LEFT
        bus.BTN_RAW[2] = 1'b1;
        p = cyc + 6;
        run(6 + 31);
        chk("repeat_train", step_train(2, p, 31), 32'h1249_2401);
        bus.BTN_RAW[2] = 1'b0;
        run(10);

        // Release timed so the debounced fall lands on relative cycle 13
        bus.BTN_RAW[2] = 1'b1;
        p = cyc + 6;
        run_until(p + 7);
        bus.BTN_RAW[2] = 1'b0;
        run_until(p + 25);
        chk("rel_train",     step_train(2, p, 25), 32'h0000_0401);
        chk("rel_pulse",     {28'h0, rel_hist[p+13]}, 32'h4);
        chk("rel_level_pre", {28'h0, level_hist[p+12]}, 32'h4);
        chk("rel_level",     {28'h0, level_hist[p+13]}, 32'h0);
        bus.BTN_RAW[2] = 1'b1;
        p2 = cyc + 6;
        run(6 + 16);
        chk("repress_train", step_train(2, p2, 16), 32'h0000_2401);
        bus.BTN_RAW[2] = 1'b0;
        run(10);

        // Independence: UP then DOWN two cycles later
        bus.BTN_RAW[0] = 1'b1;
        pu = cyc + 6;
        run(2);
        bus.BTN_RAW[1] = 1'b1;
        pd = cyc + 6;
        run_until(pd + 28);
        chk("indep_up_train",   step_train(0, pu, 28), 32'h0249_2401);
        chk("indep_down_train", step_train(1, pd, 28), 32'h0249_2401);
        chk("indep_offset",     pd - pu, 32'd2);
        chk("indep_others",     {28'h0, any_out(3, pu, pd + 27) & 4'b1100}, 32'h0);
        bus.BTN_RAW[1:0] = 2'b00;
        run(10);

        // Async reset mid-REPEAT on RIGHT
        bus.BTN_RAW[3] = 1'b1;
        p = cyc + 6;
        run_until(p + 15);
        chk("rst_pre_level", {28'h0, bus.BTN_LEVEL}, 32'h8);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outs", all_outs(), 32'h0);
        run(3);
        chk("rst_held_outs", all_outs(), 32'h0);
        rst = 1'b0;
        cr = cyc;
        pr = cr + 6;
        run_until(pr + 18);
        chk("rst_no_early", {28'h0, any_out(1, cr + 1, pr - 1) | any_out(3, cr + 1, pr - 1)}, 32'h0);
        chk("rst_press",    {28'h0, press_hist[pr]}, 32'h8);
        chk("rst_train",    step_train(3, pr, 17), 32'h0001_2401);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
